// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch, decode, then a fixed per-opcode T-step sequence driving datapath strobes.
// Latency: outputs are combinational from state/ir/con_ff; fetch is 3+MEM_WAIT cycles, memory steps last 1+MEM_WAIT cycles.
// Backpressure: none; memory steps are stretched only by the internal wait counter, and clear overrides every state.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [4:0]  OP_ADD   = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CON_in,
    output logic        PCin,
    output logic        MDRin,
    output logic        MARin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        HIin,
    output logic        LOin,
    output logic        Cin,
    output logic        OutPortin,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLOout,
    output logic        ZHIout,
    output logic        HIout,
    output logic        LOout,
    output logic        Inportout,
    output logic        Cout,
    output logic        IncPC,
    output logic        read,
    output logic        write,
    output logic [4:0]  operation,
    output logic        run,
    output logic [15:0] instr_count
);

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10011;
    localparam logic [4:0] OPC_IN   = 5'b10110;
    localparam logic [4:0] OPC_OUT  = 5'b10111;
    localparam logic [4:0] OPC_MFHI = 5'b11000;
    localparam logic [4:0] OPC_MFLO = 5'b11001;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t      state, next_state;
    logic [2:0]  wait_cnt;
    logic        done;
    logic [4:0]  opcode;
    logic        is_rr, is_imm, is_ldi, is_ld, is_st, is_br;
    logic        unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign is_rr     = opcode inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR};
    assign is_imm    = opcode inside {OPC_ADDI, OPC_ANDI, OPC_ORI};
    assign is_ldi    = (opcode == OPC_LDI);
    assign is_ld     = (opcode == OPC_LD);
    assign is_st     = (opcode == OPC_ST);
    assign is_br     = (opcode == OPC_BR);

    // Wait counter reloads on every state change; only memory steps consult it.
    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= S_RST;
            wait_cnt    <= 3'd0;
            instr_count <= 16'd0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= 3'(MEM_WAIT);
            else if (wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
            instr_count <= instr_count + {15'd0, done};
        end
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, CON_in} = '0;
        {PCin, MDRin, MARin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Cin, OutPortin} = '0;
        {PCout, MDRout, ZLOout, ZHIout, HIout, LOout, Inportout, Cout} = '0;
        {IncPC, read, write} = '0;
        operation  = 5'd0;
        run        = 1'b1;
        next_state = state;
        done       = 1'b0;

        case (state)
            S_RST: next_state = S_T0;
            S_T0: begin
                {PCout, MARin, IncPC, Zlowin} = '1;
                next_state = S_T1;
            end
            S_T1: begin
                {ZLOout, PCin, read, MDRin} = '1;
                next_state = (wait_cnt == 3'd0) ? S_T2 : S_T1;
            end
            S_T2: begin
                {MDRout, IRin} = '1;
                next_state = S_T3;
            end
            S_T3: begin
                next_state = S_T0;
                if (is_rr || is_imm) begin
                    {Grb, Rout, Yin} = '1;
                    next_state = S_T4;
                end else if (is_ldi || is_ld || is_st) begin
                    {Grb, BAout, Yin} = '1;
                    next_state = S_T4;
                end else begin
                    case (opcode)
                        OPC_BR: begin
                            {Gra, Rout, CON_in} = '1;
                            next_state = S_T4;
                        end
                        OPC_JR:   {Gra, Rout, PCin} = '1;
                        OPC_IN:   {Inportout, Gra, Rin} = '1;
                        OPC_OUT:  {Gra, Rout, OutPortin} = '1;
                        OPC_MFHI: {HIout, Gra, Rin} = '1;
                        OPC_MFLO: {LOout, Gra, Rin} = '1;
                        OPC_HALT: next_state = S_HALT;
                        default:  next_state = S_T0;
                    endcase
                end
            end
            S_T4: begin
                next_state = S_T5;
                if (is_rr) begin
                    {Grc, Rout, Zlowin} = '1;
                    operation = opcode;
                end else if (is_imm) begin
                    {Cout, Zlowin} = '1;
                    case (opcode)
                        OPC_ANDI: operation = OPC_AND;
                        OPC_ORI:  operation = OPC_OR;
                        default:  operation = OPC_ADD;
                    endcase
                end else if (is_ldi || is_ld || is_st) begin
                    {Cout, Zlowin} = '1;
                    operation = OP_ADD;
                end else if (is_br) begin
                    {PCout, Yin} = '1;
                end else begin
                    next_state = S_T0;
                end
            end
            S_T5: begin
                next_state = S_T0;
                if (is_rr || is_imm || is_ldi) begin
                    {ZLOout, Gra, Rin} = '1;
                end else if (is_ld || is_st) begin
                    {ZLOout, MARin} = '1;
                    next_state = S_T6;
                end else if (is_br) begin
                    {Cout, Zlowin} = '1;
                    operation  = OP_ADD;
                    next_state = S_T6;
                end
            end
            S_T6: begin
                next_state = S_T0;
                if (is_ld) begin
                    {read, MDRin} = '1;
                    next_state = (wait_cnt == 3'd0) ? S_T7 : S_T6;
                end else if (is_st) begin
                    // read stays low so MDR takes the bus rather than memory
                    {Gra, Rout, MDRin} = '1;
                    next_state = S_T7;
                end else if (is_br && con_ff) begin
                    {ZLOout, PCin} = '1;
                end
            end
            S_T7: begin
                next_state = S_T0;
                if (is_ld) begin
                    {MDRout, Gra, Rin} = '1;
                end else if (is_st) begin
                    write = 1'b1;
                    next_state = (wait_cnt == 3'd0) ? S_T0 : S_T7;
                end
            end
            S_HALT: begin
                run        = 1'b0;
                next_state = S_HALT;
            end
            default: next_state = S_RST;
        endcase

        done = (next_state == S_T0) && (state != S_RST);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT=1 and MEM_WAIT=2), each exercised while the other is held in clear.
// Expected per-cycle strobes come from an opcode-to-step list expanded by memory wait; a table checks cycle/strobe totals.
module tb_control_sequencer;

    localparam int B_GRA = 0,  B_GRB = 1,  B_GRC = 2,  B_RIN = 3,  B_ROUT = 4,  B_BAOUT = 5, B_CONIN = 6;
    localparam int B_PCIN = 7, B_MDRIN = 8, B_MARIN = 9, B_IRIN = 10, B_YIN = 11, B_ZLOWIN = 12;
    localparam int B_ZHIGHIN = 13, B_HIIN = 14, B_LOIN = 15, B_CIN = 16, B_OUTPORTIN = 17;
    localparam int B_PCOUT = 18, B_MDROUT = 19, B_ZLOOUT = 20, B_ZHIOUT = 21, B_HIOUT = 22;
    localparam int B_LOOUT = 23, B_INPORTOUT = 24, B_COUT = 25, B_INCPC = 26, B_READ = 27, B_WRITE = 28;

    localparam logic [28:0] M_GRA = 29'h1 << B_GRA, M_GRB = 29'h1 << B_GRB, M_GRC = 29'h1 << B_GRC;
    localparam logic [28:0] M_RIN = 29'h1 << B_RIN, M_ROUT = 29'h1 << B_ROUT, M_BAOUT = 29'h1 << B_BAOUT;
    localparam logic [28:0] M_CONIN = 29'h1 << B_CONIN, M_PCIN = 29'h1 << B_PCIN, M_MDRIN = 29'h1 << B_MDRIN;
    localparam logic [28:0] M_MARIN = 29'h1 << B_MARIN, M_IRIN = 29'h1 << B_IRIN, M_YIN = 29'h1 << B_YIN;
    localparam logic [28:0] M_ZLOWIN = 29'h1 << B_ZLOWIN, M_OUTPORTIN = 29'h1 << B_OUTPORTIN;
    localparam logic [28:0] M_PCOUT = 29'h1 << B_PCOUT, M_MDROUT = 29'h1 << B_MDROUT, M_ZLOOUT = 29'h1 << B_ZLOOUT;
    localparam logic [28:0] M_HIOUT = 29'h1 << B_HIOUT, M_LOOUT = 29'h1 << B_LOOUT;
    localparam logic [28:0] M_INPORTOUT = 29'h1 << B_INPORTOUT, M_COUT = 29'h1 << B_COUT;
    localparam logic [28:0] M_INCPC = 29'h1 << B_INCPC, M_READ = 29'h1 << B_READ, M_WRITE = 29'h1 << B_WRITE;
    localparam logic [28:0] M_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;

    logic        clock = 1'b0;
    logic        clr   [2];
    logic [31:0] ir_v  [2];
    logic        con_v [2];
    wire  [28:0] sb    [2];
    wire  [4:0]  op    [2];
    wire         run   [2];
    wire  [15:0] cnt   [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        control_sequencer #(.MEM_WAIT(g + 1), .OP_ADD(5'b00011)) u_dut (
            .clock(clock), .clear(clr[g]), .ir(ir_v[g]), .con_ff(con_v[g]),
            .Gra(sb[g][B_GRA]), .Grb(sb[g][B_GRB]), .Grc(sb[g][B_GRC]), .Rin(sb[g][B_RIN]),
            .Rout(sb[g][B_ROUT]), .BAout(sb[g][B_BAOUT]), .CON_in(sb[g][B_CONIN]),
            .PCin(sb[g][B_PCIN]), .MDRin(sb[g][B_MDRIN]), .MARin(sb[g][B_MARIN]), .IRin(sb[g][B_IRIN]),
            .Yin(sb[g][B_YIN]), .Zlowin(sb[g][B_ZLOWIN]), .Zhighin(sb[g][B_ZHIGHIN]), .HIin(sb[g][B_HIIN]),
            .LOin(sb[g][B_LOIN]), .Cin(sb[g][B_CIN]), .OutPortin(sb[g][B_OUTPORTIN]),
            .PCout(sb[g][B_PCOUT]), .MDRout(sb[g][B_MDROUT]), .ZLOout(sb[g][B_ZLOOUT]),
            .ZHIout(sb[g][B_ZHIOUT]), .HIout(sb[g][B_HIOUT]), .LOout(sb[g][B_LOOUT]),
            .Inportout(sb[g][B_INPORTOUT]), .Cout(sb[g][B_COUT]), .IncPC(sb[g][B_INCPC]),
            .read(sb[g][B_READ]), .write(sb[g][B_WRITE]),
            .operation(op[g]), .run(run[g]), .instr_count(cnt[g])
        );
    end

    typedef struct { logic [28:0] s; logic [4:0] op; } step_t;
    typedef struct { logic [31:0] ir; bit con; int cyc; int rd; int wr; int pc; } vec_t;

    step_t       exp_q [$];
    logic [15:0] exp_cnt [2];
    int          n_err = 0;
    int          n_chk = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // A memory step appears 1+mw times in the expected trace.
    task automatic push(logic [28:0] s, logic [4:0] o, bit mem, int mw);
        step_t st;
        st.s = s;
        st.op = o;
        exp_q.push_back(st);
        if (mem) repeat (mw) exp_q.push_back(st);
    endtask

    task automatic build(int mw, logic [4:0] opc, bit c);
        exp_q.delete();
        push(M_T0, 5'd0, 1'b0, mw);
        push(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1, mw);
        push(M_MDROUT | M_IRIN, 5'd0, 1'b0, mw);
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0, mw);
                push(M_GRC | M_ROUT | M_ZLOWIN, opc, 1'b0, mw);
                push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0, mw);
            end
            5'd12, 5'd13, 5'd14: begin
                push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0, mw);
                push(M_COUT | M_ZLOWIN, (opc == 5'd12) ? 5'd3 : (opc == 5'd13) ? 5'd5 : 5'd6, 1'b0, mw);
                push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0, mw);
            end
            5'd0, 5'd1, 5'd2: begin
                push(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0, mw);
                push(M_COUT | M_ZLOWIN, 5'd3, 1'b0, mw);
                if (opc == 5'd1) begin
                    push(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0, mw);
                end else if (opc == 5'd0) begin
                    push(M_ZLOOUT | M_MARIN, 5'd0, 1'b0, mw);
                    push(M_READ | M_MDRIN, 5'd0, 1'b1, mw);
                    push(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0, mw);
                end else begin
                    push(M_ZLOOUT | M_MARIN, 5'd0, 1'b0, mw);
                    push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0, mw);
                    push(M_WRITE, 5'd0, 1'b1, mw);
                end
            end
            5'd18: begin
                push(M_GRA | M_ROUT | M_CONIN, 5'd0, 1'b0, mw);
                push(M_PCOUT | M_YIN, 5'd0, 1'b0, mw);
                push(M_COUT | M_ZLOWIN, 5'd3, 1'b0, mw);
                push(c ? (M_ZLOOUT | M_PCIN) : 29'd0, 5'd0, 1'b0, mw);
            end
            5'd19: push(M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b0, mw);
            5'd22: push(M_INPORTOUT | M_GRA | M_RIN, 5'd0, 1'b0, mw);
            5'd23: push(M_GRA | M_ROUT | M_OUTPORTIN, 5'd0, 1'b0, mw);
            5'd24: push(M_HIOUT | M_GRA | M_RIN, 5'd0, 1'b0, mw);
            5'd25: push(M_LOOUT | M_GRA | M_RIN, 5'd0, 1'b0, mw);
            default: push(29'd0, 5'd0, 1'b0, mw);
        endcase
    endtask

    // Entered and left at a falling edge where the instance shows T0.
    task automatic exec(int g, logic [31:0] instr, bit c);
        ir_v[g]  = instr;
        con_v[g] = c;
        build(g + 1, instr[31:27], c);
        foreach (exp_q[i]) begin
            if (i > 0) @(negedge clock);
            chk($sformatf("trace_u%0d_op%0h_step%0d", g, instr[31:27], i),
                {sb[g], op[g], run[g]}, {exp_q[i].s, exp_q[i].op, 1'b1});
        end
        if (instr[31:27] != 5'b11011) begin
            @(negedge clock);
            exp_cnt[g] = exp_cnt[g] + 16'd1;
            chk($sformatf("count_u%0d", g), cnt[g], exp_cnt[g]);
            chk($sformatf("refetch_u%0d", g), sb[g], M_T0);
        end
    endtask

    task automatic measure(int g, logic [31:0] instr, bit c, output int cyc, output int rd,
                           output int wr, output int pc);
        ir_v[g]  = instr;
        con_v[g] = c;
        cyc = 0; rd = 0; wr = 0; pc = 0;
        do begin
            rd += int'(sb[g][B_READ]);
            wr += int'(sb[g][B_WRITE]);
            pc += int'(sb[g][B_PCIN]);
            cyc++;
            @(negedge clock);
        end while (sb[g] != M_T0 && cyc < 40);
        exp_cnt[g] = exp_cnt[g] + 16'd1;
    endtask

    task automatic do_reset(int g);
        clr[g] = 1'b1;
        repeat (2) @(negedge clock);
        chk($sformatf("rst_outputs_u%0d", g), {sb[g], op[g], run[g]}, 64'h1);
        chk($sformatf("rst_count_u%0d", g), cnt[g], 64'h0);
        exp_cnt[g] = 16'd0;
        clr[g] = 1'b0;
        @(negedge clock);
        chk($sformatf("t0_after_rst_u%0d", g), {sb[g], op[g], run[g]}, {M_T0, 5'd0, 1'b1});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        int          cyc, rd, wr, pc;
        logic [4:0]  opc;
        logic [31:0] instr;

        tbl[0]  = '{32'h18918000,       1'b0, 7,  2, 0, 2};
        tbl[1]  = '{{5'b00100, 27'h0},  1'b0, 7,  2, 0, 2};
        tbl[2]  = '{{5'b01101, 27'h0},  1'b0, 7,  2, 0, 2};
        tbl[3]  = '{{5'b00001, 27'h0},  1'b0, 7,  2, 0, 2};
        tbl[4]  = '{{5'b00000, 27'h0},  1'b0, 10, 4, 0, 2};
        tbl[5]  = '{{5'b00010, 27'h0},  1'b0, 10, 2, 2, 2};
        tbl[6]  = '{{5'b10010, 27'h0},  1'b1, 8,  2, 0, 3};
        tbl[7]  = '{{5'b10010, 27'h0},  1'b0, 8,  2, 0, 2};
        tbl[8]  = '{{5'b10011, 27'h0},  1'b0, 5,  2, 0, 3};
        tbl[9]  = '{{5'b10110, 27'h0},  1'b0, 5,  2, 0, 2};
        tbl[10] = '{{5'b11001, 27'h0},  1'b0, 5,  2, 0, 2};
        tbl[11] = '{{5'b11111, 27'h0},  1'b0, 5,  2, 0, 2};

        clr[0] = 1'b1; clr[1] = 1'b1;
        ir_v[0] = 32'd0; ir_v[1] = 32'd0;
        con_v[0] = 1'b0; con_v[1] = 1'b0;
        exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0;

        // Instance 0, MEM_WAIT=1
        do_reset(0);
        exec(0, 32'h18918000, 1'b0);
        foreach (tbl[k]) begin
            measure(0, tbl[k].ir, tbl[k].con, cyc, rd, wr, pc);
            chk($sformatf("tbl%0d_cycles", k), cyc, tbl[k].cyc);
            chk($sformatf("tbl%0d_reads", k), rd, tbl[k].rd);
            chk($sformatf("tbl%0d_writes", k), wr, tbl[k].wr);
            chk($sformatf("tbl%0d_pcin", k), pc, tbl[k].pc);
            chk($sformatf("tbl%0d_count", k), cnt[0], exp_cnt[0]);
        end
        exec(0, {5'b10010, 27'h123}, 1'b1);
        exec(0, {5'b10010, 27'h456}, 1'b0);
        for (int n = 0; n < 40; n++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'b11011) opc = 5'b11010;
            instr = {opc, 27'($urandom)};
            exec(0, instr, 1'($urandom_range(0, 1)));
        end
        exec(0, 32'hD8000000, 1'b0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            chk("halt_outputs", {sb[0], op[0], run[0]}, 64'h0);
            chk("halt_count", cnt[0], exp_cnt[0]);
        end
        clr[0] = 1'b1;
        @(negedge clock);
        chk("halt_clear_rst", {sb[0], op[0], run[0]}, 64'h1);
        clr[0] = 1'b0;
        @(negedge clock);
        exp_cnt[0] = 16'd0;
        chk("halt_restart_fetch", {sb[0], op[0], run[0]}, {M_T0, 5'd0, 1'b1});
        chk("halt_restart_count", cnt[0], exp_cnt[0]);
        clr[0] = 1'b1;

        // Instance 1, MEM_WAIT=2
        do_reset(1);
        exec(1, {5'b00000, 27'h0ABCDEF}, 1'b0);
        measure(1, {5'b00000, 27'h0}, 1'b0, cyc, rd, wr, pc);
        chk("ld_w2_cycles", cyc, 12);
        chk("ld_w2_reads", rd, 6);
        chk("ld_w2_writes", wr, 0);
        measure(1, {5'b00010, 27'h0}, 1'b0, cyc, rd, wr, pc);
        chk("st_w2_cycles", cyc, 12);
        chk("st_w2_reads", rd, 3);
        chk("st_w2_writes", wr, 3);
        for (int n = 0; n < 30; n++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'b11011) opc = 5'b00000;
            instr = {opc, 27'($urandom)};
            exec(1, instr, 1'($urandom_range(0, 1)));
        end

        // clear in the middle of ld's data-read wait
        ir_v[1] = {5'b00000, 27'h0};
        repeat (9) @(negedge clock);
        chk("ld_mid_wait_read", {sb[1][B_READ], sb[1][B_WRITE]}, 64'h2);
        clr[1] = 1'b1;
        @(negedge clock);
        chk("mid_wait_clear_rst", {sb[1], op[1], run[1]}, 64'h1);
        chk("mid_wait_clear_count", cnt[1], 64'h0);
        exp_cnt[1] = 16'd0;
        clr[1] = 1'b0;
        @(negedge clock);
        chk("mid_wait_refetch", sb[1], M_T0);

        // counter wrap: preload the count, then one nop
        force gen_dut[1].u_dut.instr_count = 16'hFFFF;
        #1;
        release gen_dut[1].u_dut.instr_count;
        exp_cnt[1] = 16'hFFFF;
        exec(1, {5'b11010, 27'h0}, 1'b0);
        chk("wrap_zero", cnt[1], 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
